// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
//   stall_state_t : controller FSM state encoding
//   REG_PC        : register index of the program counter (r15)
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } stall_state_t;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/enable bundle between the decode-side pipeline and the stall controller.
//   master : pipeline side, drives hazard inputs, receives enables/flushes/status
//   slave  : stall controller side
//   id_rn/id_rm/id_uses_rn/id_uses_rm : source operands of the ID instruction
//   ex_rd/ex_is_load/ex_reg_write/ex_branch_taken : EX instruction info
//   mem_busy : data memory not ready
//   pc_en/ifid_en/idex_en/exmem_en : pipeline flop enables
//   ifid_flush/idex_flush : synchronous bubble insert
//   stall_cycles/mem_timeout : status
interface pipeline_stall_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rn;
    logic [REG_W-1:0] id_rm;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic [REG_W-1:0] ex_rd;
    logic             ex_is_load;
    logic             ex_reg_write;
    logic             ex_branch_taken;
    logic             mem_busy;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic             mem_timeout;

    modport master (
        output id_rn, id_rm, id_uses_rn, id_uses_rm,
        output ex_rd, ex_is_load, ex_reg_write, ex_branch_taken, mem_busy,
        input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
        input  stall_cycles, mem_timeout
    );

    modport slave (
        input  id_rn, id_rm, id_uses_rn, id_uses_rm,
        input  ex_rd, ex_is_load, ex_reg_write, ex_branch_taken, mem_busy,
        output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
        output stall_cycles, mem_timeout
    );

endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count up by one (ignored once at MAX)
//   clr        : synchronous clear, wins over inc
//   q          : current count
//   at_max     : count equals MAX
module pipeline_stall_ctrl_sat_counter #(
    parameter int           W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         at_max
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max = (cnt_q == MAX);
    assign q      = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline. Sources the enable and
// synchronous clear of PC, IF/ID, ID/EX and EX/MEM flops.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of pipeline_stall_ctrl_if (hazard inputs in,
//           enables/flushes/stall_cycles/mem_timeout out)
// Priority each cycle: mem_busy > taken branch > load-use > normal.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int REG_W    = 4,
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_stall_ctrl_if.slave bus
);

    stall_state_t state_q;
    stall_state_t state_d;
    logic         state_en;

    logic         hazard;
    logic         pc_en_c;
    logic         ifid_en_c;
    logic         idex_en_c;
    logic         exmem_en_c;
    logic         ifid_flush_c;
    logic         idex_flush_c;

    logic [CNT_W-1:0] stall_cnt;
    logic             stall_at_max;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_at_max;
    logic             timeout_q;
    logic             timeout_d;

    // r15 destinations are redirected through the branch path, never a bubble.
    assign hazard = bus.ex_is_load && bus.ex_reg_write &&
                    (bus.ex_rd != REG_W'(REG_PC)) &&
                    ((bus.id_uses_rn && (bus.id_rn == bus.ex_rd)) ||
                     (bus.id_uses_rm && (bus.id_rm == bus.ex_rd)));

    // State register: enabled flop with the enable permanently asserted.
    assign state_en = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else if (state_en) begin
            state_q <= state_d;
        end
    end

    // Next-state logic. LOAD_STALL never re-arms itself: the load has moved
    // on to MEM, so exactly one bubble is inserted per load-use.
    always_comb begin
        state_d = RUN;
        if (bus.mem_busy) begin
            state_d = MEM_WAIT;
        end else if (bus.ex_branch_taken) begin
            state_d = RUN;
        end else if ((state_q != LOAD_STALL) && hazard) begin
            state_d = LOAD_STALL;
        end
    end

    // Output logic, combinational so enables act in the same cycle.
    always_comb begin
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        if (!reset) begin
            if (bus.mem_busy) begin
                // Whole pipe frozen; a pending branch stays in EX and is
                // acted on once memory is ready.
                pc_en_c    = 1'b0;
                ifid_en_c  = 1'b0;
                idex_en_c  = 1'b0;
                exmem_en_c = 1'b0;
            end else if (bus.ex_branch_taken) begin
                ifid_flush_c = 1'b1;
                idex_flush_c = 1'b1;
            end else if ((state_q != LOAD_STALL) && hazard) begin
                // Hold PC and IF/ID, push a bubble into ID/EX, let the load advance.
                pc_en_c      = 1'b0;
                ifid_en_c    = 1'b0;
                idex_flush_c = 1'b1;
            end
        end
    end

    pipeline_stall_ctrl_sat_counter #(
        .W   (CNT_W)
    ) u_stall_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (!pc_en_c && !stall_at_max),
        .clr    (1'b0),
        .q      (stall_cnt),
        .at_max (stall_at_max)
    );

    // Consecutive mem_busy cycles; any ready cycle restarts the count.
    pipeline_stall_ctrl_sat_counter #(
        .W   (CNT_W),
        .MAX (CNT_W'(MAX_WAIT))
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (bus.mem_busy),
        .clr    (!bus.mem_busy),
        .q      (wait_cnt),
        .at_max (wait_at_max)
    );

    // Timeout is visible right after the MAX_WAIT-th busy cycle (wait count
    // at max) and is then held by timeout_q until reset.
    assign timeout_d = timeout_q || wait_at_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign bus.pc_en        = pc_en_c;
    assign bus.ifid_en      = ifid_en_c;
    assign bus.idex_en      = idex_en_c;
    assign bus.exmem_en     = exmem_en_c;
    assign bus.ifid_flush   = ifid_flush_c;
    assign bus.idex_flush   = idex_flush_c;
    assign bus.stall_cycles = stall_cnt;
    assign bus.mem_timeout  = timeout_q || wait_at_max;

endmodule
